mmio_uart_fifo: RTL and testbench



---
 rtl/mmio_uart_fifo.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_mmio_uart_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, programmable baud divisor, sticky error flags
// and a level interrupt, decoded on the pipelined MIPS data bus.

module mmio_uart_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: storage is deliberately left unreset; pointers and count alone mark valid entries.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= wdata_i;
    end
endmodule

module mmio_uart_fifo #(
    parameter logic [31:0] BASE_ADDR   = 32'h40000018,
    parameter int          DATA_W      = 8,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd10417,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        hit,
    input  logic        Rx_Serial,
    output logic        Tx_Serial,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [2:0] R_TXD = 3'd0, R_RXD = 3'd1, R_STATUS = 3'd2, R_CTRL = 3'd3, R_IRQEN = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    logic [31:0] off;
    logic [2:0]  reg_sel;
    logic        wr_en, rd_en, status_rd;
    logic        unused_wdata;

    logic [15:0] div_q;
    logic        tx_en_q, rx_en_q, loop_q, irq_q;
    logic [2:0]  irq_en_q;
    logic        ovr_q, frm_q, ovf_q;

    uart_state_e        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0]        tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [15:0]        rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [BW-1:0]      tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic               tx_line_q, tx_line_d, rx_prev_q;
    logic [SYNC_STAGES-1:0] sync_q;

    logic              tx_push, tx_pop, tx_full, tx_empty, tx_tick, tx_active;
    logic              rx_push, rx_pop, rx_full, rx_empty, rx_tick, rx_half, rx_line;
    logic              frm_set, ovr_set, ovf_set;
    logic [DATA_W-1:0] tx_head, rx_head;
    logic [CW-1:0]     tx_count, rx_count;
    logic [31:0]       status;

    assign off          = Address - BASE_ADDR;
    assign hit          = (off < 32'h14);
    assign reg_sel      = off[4:2];
    assign wr_en        = hit && MemWrite;
    assign rd_en        = hit && MemRead;
    assign status_rd    = rd_en && (reg_sel == R_STATUS);
    assign unused_wdata = &{1'b0, Write_data[31:19]};

    assign tx_push = wr_en && (reg_sel == R_TXD);
    assign rx_pop  = rd_en && (reg_sel == R_RXD) && !rx_empty;
    assign ovf_set = tx_push && tx_full && !tx_pop;
    assign ovr_set = rx_push && rx_full && !rx_pop;

    mmio_uart_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push_i(tx_push), .pop_i(tx_pop),
        .wdata_i(Write_data[DATA_W-1:0]), .rdata_o(tx_head), .count_o(tx_count),
        .full_o(tx_full), .empty_o(tx_empty)
    );

    mmio_uart_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push_i(rx_push), .pop_i(rx_pop),
        .wdata_i(rx_sh_q), .rdata_o(rx_head), .count_o(rx_count),
        .full_o(rx_full), .empty_o(rx_empty)
    );

    assign tx_tick   = (tx_cnt_q == tx_div_q - 16'd1);
    assign tx_active = (tx_state_q != S_IDLE);
    assign Tx_Serial = tx_line_q;

    // NOTE: every _d takes its _q value first, so no branch can leave a latch behind.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_div_d   = tx_div_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_line_d = 1'b1;
                tx_cnt_d  = '0;
                if (tx_en_q && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_head;
                    tx_div_d   = div_q;
                    tx_line_d  = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: if (tx_tick) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_line_d  = tx_sh_q[0];
                tx_sh_d    = tx_sh_q >> 1;
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_tick) begin
                tx_cnt_d = '0;
                if (tx_bit_q == BW'(DATA_W - 1)) begin
                    tx_line_d  = 1'b1;
                    tx_state_d = S_STOP;
                end else begin
                    tx_bit_d  = tx_bit_q + 1'b1;
                    tx_line_d = tx_sh_q[0];
                    tx_sh_d   = tx_sh_q >> 1;
                end
            end
            default: if (tx_tick) begin
                tx_cnt_d   = '0;
                tx_state_d = S_IDLE;
            end
        endcase
    end

    // Loopback substitutes the transmitter output for the synchronised pin.
    assign rx_line = loop_q ? tx_line_q : sync_q[SYNC_STAGES-1];
    assign rx_tick = (rx_cnt_q == rx_div_q - 16'd1);
    assign rx_half = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_div_d   = rx_div_q;
        rx_push    = 1'b0;
        frm_set    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_en_q && rx_prev_q && !rx_line) begin
                    rx_div_d   = div_q;
                    rx_state_d = S_START;
                end
            end
            S_START: if (rx_half) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_line ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_tick) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_line, rx_sh_q[DATA_W-1:1]};
                if (rx_bit_q == BW'(DATA_W - 1)) rx_state_d = S_STOP;
                else                             rx_bit_d   = rx_bit_q + 1'b1;
            end
            default: if (rx_tick) begin
                rx_cnt_d   = '0;
                rx_state_d = S_IDLE;
                if (rx_line) rx_push = 1'b1;
                else         frm_set = 1'b1;
            end
        endcase
    end

    assign status = {8'(tx_count), 8'(rx_count), 8'h00, ovf_q, frm_q, ovr_q,
                     tx_active, tx_empty, tx_full, rx_full, !rx_empty};

    always_comb begin
        Read_data = '0;
        if (hit) begin
            case (reg_sel)
                R_RXD:    Read_data = rx_empty ? 32'hFFFF_FFFF : 32'(rx_head);
                R_STATUS: Read_data = status;
                R_CTRL:   Read_data = {13'd0, loop_q, rx_en_q, tx_en_q, div_q};
                R_IRQEN:  Read_data = {29'd0, irq_en_q};
                default:  Read_data = '0;
            endcase
        end
    end

    // NOTE: all state updates use <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q      <= DEFAULT_DIV;
            tx_en_q    <= 1'b1;
            rx_en_q    <= 1'b1;
            loop_q     <= 1'b0;
            irq_en_q   <= '0;
            ovr_q      <= 1'b0;
            frm_q      <= 1'b0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_div_q   <= DEFAULT_DIV;
            tx_line_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_div_q   <= DEFAULT_DIV;
            rx_prev_q  <= 1'b1;
            sync_q     <= '1;
        end else begin
            if (wr_en && reg_sel == R_CTRL) begin
                div_q   <= (Write_data[15:1] == '0) ? 16'd2 : Write_data[15:0];
                tx_en_q <= Write_data[16];
                rx_en_q <= Write_data[17];
                loop_q  <= Write_data[18];
            end
            if (wr_en && reg_sel == R_IRQEN) irq_en_q <= Write_data[2:0];
            // Set wins over the read-clear when both land on the same edge.
            ovr_q      <= (ovr_q && !status_rd) || ovr_set;
            frm_q      <= (frm_q && !status_rd) || frm_set;
            ovf_q      <= (ovf_q && !status_rd) || ovf_set;
            irq_q      <= (irq_en_q[0] && !rx_empty) || (irq_en_q[1] && tx_empty) ||
                          (irq_en_q[2] && (ovr_q || frm_q || ovf_q));
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_div_q   <= tx_div_d;
            tx_line_q  <= tx_line_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_div_q   <= rx_div_d;
            rx_prev_q  <= rx_line;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], Rx_Serial};
        end
    end

    assign irq = irq_q;
endmodule

// File: tb/tb_mmio_uart_fifo.sv
// Directed self-checking bench for mmio_uart_fifo: register access, TX framing,
// loopback receive, FIFO overflow, framing error with interrupt, and mid-frame reset.

module tb_mmio_uart_fifo;
    localparam logic [31:0] BASE = 32'h40000018;
    localparam logic [4:0]  O_TXD = 5'h00, O_RXD = 5'h04, O_STATUS = 5'h08, O_CTRL = 5'h0C, O_IRQEN = 5'h10;

    logic        clk = 1'b0;
    logic        reset, MemRead, MemWrite, Rx_Serial;
    logic [31:0] Address, Write_data, Read_data;
    logic        hit, Tx_Serial, irq;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_uart_fifo #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data), .hit(hit),
        .Rx_Serial(Rx_Serial), .Tx_Serial(Tx_Serial), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] o, input logic [31:0] d);
        @(negedge clk);
        Address    = BASE + 32'(o);
        Write_data = d;
        MemWrite   = 1'b1;
        @(negedge clk);
        MemWrite   = 1'b0;
        Address    = 32'h0;
    endtask

    task automatic bus_read(input logic [4:0] o, output logic [31:0] d);
        @(negedge clk);
        Address = BASE + 32'(o);
        MemRead = 1'b1;
        #1 d = Read_data;
        @(negedge clk);
        MemRead = 1'b0;
        Address = 32'h0;
    endtask

    logic [31:0] rd;
    logic [9:0]  frame;
    logic [39:0] obs, expw;
    int          active;
    logic        fl [80];
    logic        iq [80];
    int          idx;

    initial begin
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Rx_Serial = 1'b1;
        Address = 32'h0; Write_data = 32'h0;
        repeat (3) @(negedge clk);
        check("tx_in_reset", Tx_Serial, 1'b1);
        check("irq_in_reset", irq, 1'b0);
        reset = 1'b1;

        // Reset state and decode.
        bus_read(O_CTRL, rd);   check("ctrl_reset", rd, 32'h0003_28B1);
        bus_read(O_STATUS, rd); check("status_reset", rd, 32'h0000_0008);
        check("tx_idle", Tx_Serial, 1'b1);
        @(negedge clk);
        Address = BASE + 32'h14; #1;
        check("hit_above", {hit, Read_data}, {1'b0, 32'h0});
        Address = BASE - 32'h4; #1;
        check("hit_below", hit, 1'b0);
        Address = BASE + 32'h0C; #1;
        check("hit_ctrl_comb", {hit, Read_data}, {1'b1, 32'h0003_28B1});
        Address = 32'h0;

        // tx_empty interrupt, one clock after the enable lands.
        bus_write(O_IRQEN, 32'h2);
        @(negedge clk);
        check("irq_tx_empty", irq, 1'b1);
        bus_read(O_IRQEN, rd);  check("irq_en_rb", rd, 32'h2);
        bus_write(O_IRQEN, 32'h0);

        // Divisor below 2 clamps to 2.
        bus_write(O_CTRL, 32'h0003_0001);
        bus_read(O_CTRL, rd);   check("div_clamp", rd, 32'h0003_0002);

        // TX frame 0xA5 at div=4.
        bus_write(O_CTRL, 32'h0003_0004);
        bus_write(O_TXD, 32'h0000_00A5);
        Address = BASE + 32'(O_STATUS); #1;
        check("tx_pre_start", {Tx_Serial, Read_data[4]}, 2'b10);
        frame  = {1'b1, 8'hA5, 1'b0};
        active = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk); #1;
            if (i < 40) begin
                obs[i]  = Tx_Serial;
                expw[i] = frame[i/4];
            end
            if (Read_data[4]) active++;
        end
        Address = 32'h0;
        check("tx_wave_a5", obs, expw);
        check("tx_active_clocks", active, 40);
        check("tx_idle_after", Tx_Serial, 1'b1);

        // Loopback of three bytes.
        bus_write(O_CTRL, 32'h0007_0004);
        bus_write(O_TXD, 32'h11);
        bus_write(O_TXD, 32'h22);
        bus_write(O_TXD, 32'h33);
        rd = 32'h0;
        for (int k = 0; k < 300 && rd[23:16] != 8'd3; k++) bus_read(O_STATUS, rd);
        check("loop_rx_count", rd[23:16], 8'd3);
        bus_read(O_RXD, rd); check("rxd_0", rd, 32'h11);
        bus_read(O_RXD, rd); check("rxd_1", rd, 32'h22);
        bus_read(O_RXD, rd); check("rxd_2", rd, 32'h33);
        bus_read(O_RXD, rd); check("rxd_empty", rd, 32'hFFFF_FFFF);

        // TX overflow with the transmitter disabled.
        bus_write(O_CTRL, 32'h0002_0004);
        for (int k = 1; k <= 5; k++) bus_write(O_TXD, 32'(k));
        bus_read(O_STATUS, rd); check("status_overflow", rd, 32'h0400_0084);
        bus_read(O_STATUS, rd); check("status_sticky_clr", rd, 32'h0400_0004);

        // Frame with a 0 stop bit: frame_err, no push, irq one clock later.
        bus_write(O_IRQEN, 32'h4);
        @(negedge clk);
        check("irq_err_idle", irq, 1'b0);
        Address = BASE + 32'(O_STATUS);
        frame = {1'b0, 8'h3C, 1'b0};
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            Rx_Serial = (i < 40) ? frame[i/4] : 1'b1;
            #1;
            fl[i] = Read_data[6];
            iq[i] = irq;
        end
        idx = -1;
        for (int i = 0; i < 79; i++) if (idx < 0 && fl[i]) idx = i;
        check("frame_err_seen", idx >= 0, 1'b1);
        if (idx >= 0) begin
            check("irq_same_clk", iq[idx], 1'b0);
            check("irq_next_clk", iq[idx+1], 1'b1);
        end
        #1 check("status_frame_err", Read_data, 32'h0400_0044);
        Address = 32'h0;

        // Reset in the middle of a frame.
        bus_write(O_CTRL, 32'h0003_0004);
        @(negedge clk);
        check("tx_mid_frame", {Tx_Serial, irq}, 2'b01);
        reset = 1'b0;
        @(negedge clk);
        check("tx_after_reset", {Tx_Serial, irq}, 2'b10);
        reset = 1'b1;
        bus_read(O_CTRL, rd);   check("ctrl_after_reset", rd, 32'h0003_28B1);
        bus_read(O_STATUS, rd); check("status_after_reset", rd, 32'h0000_0008);
        bus_read(O_IRQEN, rd);  check("irqen_after_reset", rd, 32'h0);
        repeat (8) @(negedge clk);
        check("tx_quiet_after_reset", Tx_Serial, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
